// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_fifo_pkg
//  Brief   : Shared UART constants: byte width, default FIFO depth and the
//            receiver's clock/bit-rate settings.
//  Revision: 1.0  initial release
// ============================================================================
package uart_rx_fifo_pkg;

    // Width of one received byte
    localparam int DEF_PAYLOAD_BITS = 8;

    // Default number of receive FIFO entries (power of two, >= 2)
    localparam int DEF_DEPTH        = 8;

    // Receiver timing constants, used by the upstream bit sampler
    localparam int CLK_HZ           = 50_000_000;
    localparam int BIT_RATE         = 115_200;

    // Width of an occupancy counter able to hold 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : uart_rx_fifo_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_fifo_if
//  Brief   : Receive-side bundle between the UART receiver / consumer and the
//            receive FIFO. slave = FIFO side, master = driver side.
//  Revision: 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int DEPTH        = DEF_DEPTH
);
    localparam int C_CNT_W = cnt_width(DEPTH);

    logic                    rx_valid;
    logic [PAYLOAD_BITS-1:0] rx_data;
    logic                    rx_break;
    logic                    rd_en;
    logic                    clr_flags;
    logic [PAYLOAD_BITS-1:0] rd_data;
    logic                    empty;
    logic                    full;
    logic [C_CNT_W-1:0]      count;
    logic                    overflow;
    logic                    break_seen;

    modport slave (
        input  rx_valid, rx_data, rx_break, rd_en, clr_flags,
        output rd_data, empty, full, count, overflow, break_seen
    );

    modport master (
        output rx_valid, rx_data, rx_break, rd_en, clr_flags,
        input  rd_data, empty, full, count, overflow, break_seen
    );

endinterface : uart_rx_fifo_if
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module  : uart_fifo_mem
//  Brief   : FIFO storage array, one synchronous write port and one
//            asynchronous read port. Contents are not reset.
//  Revision: 1.0  initial release
// ============================================================================
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_PAYLOAD_BITS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [WIDTH-1:0]  wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming byte at the write address when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_fifo
//  Brief   : First-word-fall-through receive FIFO behind a UART receiver,
//            with sticky overflow and BREAK flags.
//  Revision: 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int DEPTH        = DEF_DEPTH
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    uart_rx_fifo_if.slave bus
);

    localparam int C_ADDR_W = $clog2(DEPTH);
    localparam int C_CNT_W  = cnt_width(DEPTH);

    logic [C_ADDR_W-1:0]     r_wr_ptr;
    logic [C_ADDR_W-1:0]     r_rd_ptr;
    logic [C_CNT_W-1:0]      r_count;
    logic                    r_overflow;
    logic                    r_break_seen;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic                    w_drop;
    logic [PAYLOAD_BITS-1:0] w_head;

    // Accept decisions: a read frees the slot a same-cycle write needs when full.
    // A read while empty is ignored, so empty + read + write is a plain write.
    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == C_CNT_W'(DEPTH));
        w_rd_acc = bus.rd_en & ~w_empty;
        w_wr_acc = bus.rx_valid & (~w_full | w_rd_acc);
        w_drop   = bus.rx_valid & ~w_wr_acc;
    end

    // Pointer and occupancy update; power-of-two depth makes the wrap implicit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + C_ADDR_W'(1);
            end
            r_count <= r_count + C_CNT_W'(w_wr_acc) - C_CNT_W'(w_rd_acc);
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_break_seen <= 1'b0;
        end else begin
            r_overflow   <= w_drop       | (r_overflow   & ~bus.clr_flags);
            r_break_seen <= bus.rx_break | (r_break_seen & ~bus.clr_flags);
        end
    end

    uart_fifo_mem #(
        .WIDTH  (PAYLOAD_BITS),
        .DEPTH  (DEPTH),
        .ADDR_W (C_ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_acc & rst_n),
        .waddr (r_wr_ptr),
        .wdata (bus.rx_data),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    assign bus.rd_data    = w_empty ? '0 : w_head;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.break_seen = r_break_seen;

endmodule : uart_rx_fifo
`default_nettype wire
